mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage for the RV32I pipeline, sitting between EX and write-back.
//  - Load/store ops: sequences byte-serial accesses to the 8-bit RAM port, with little-endian byte order.
//  - Loads: sign- or zero-extends the loaded value.
//  - All ops: hands the write-back triple (rd, write-enable, data) forward.
//  - Raises a stall request while a multi-cycle access is in flight.
// PARAMETERS
//  ADDR_W  32  width of the effective address and the RAM address bus
//  XLEN    32  register width; only 32 is supported
// PORTS
//  clk            in   1       clock; all state updates on rising edge
//  rst            in   1       asynchronous, active-low reset
//  in_valid       in   1       EX presents an op this cycle
//  in_ready       out  1       stage can accept an op (comb.)
//  is_load        in   1       op is a load
//  is_store       in   1       op is a store; is_load & is_store together is illegal
//  funct3         in   3       width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  wd_i           in   5       destination register
//  wreg_i         in   1       destination write enable
//  wdata_i        in   XLEN    ALU result; the effective address for loads/stores
//  mem_w_data_i   in   XLEN    store data (rs2)
//  mem_a          out  ADDR_W  RAM byte address
//  mem_dout       out  8       RAM write byte
//  mem_wr         out  1       RAM write strobe
//  mem_din        in   8       RAM read byte; valid the cycle after mem_a is driven
//  stall_req      out  1       hold IF/ID/EX (comb.)
//  out_valid      out  1       write-back triple valid (1-cycle pulse)
//  wd_o           out  5       destination register to write-back
//  wreg_o         out  1       write enable to write-back; forced 0 when wd_o==0
//  wdata_o        out  XLEN    write-back data
// BEHAVIOUR
//  Reset: state=IDLE. All of the following are 0 immediately (async):
//    out_valid, wreg_o, wd_o, wdata_o, mem_a, mem_dout, mem_wr, byte counter.
//  States: IDLE, LOAD, STORE, DONE.
//  Handshake:
//  - in_ready = (state==IDLE || state==DONE).
//  - An op is accepted on a rising edge with in_valid & in_ready.
//  - Op fields are latched at acceptance; inputs are don't-care afterwards.
//  Next state on acceptance:
//  - Load -> LOAD. Store -> STORE. Other op -> DONE, with wdata_o=wdata_i.
//  - DONE with no acceptance -> IDLE.
//  Byte count N: 1 for B/BU, 2 for H/HU, 4 for W. Other funct3 values are treated as W.
//  LOAD: cnt = 0..N, N+1 cycles.
//  - While cnt<N: drive mem_a = addr + cnt, with mem_wr=0.
//  - While cnt>=1: capture mem_din as byte cnt-1.
//  - After the cnt==N cycle -> DONE.
//  - In DONE, wdata_o holds the assembled value: sign-extended for B/H, zero-extended for BU/HU.
//  STORE: cnt = 0..N-1, N cycles.
//  - Each cycle: mem_a = addr + cnt, mem_dout = data[8*cnt+7:8*cnt], mem_wr=1.
//  - After the last byte -> DONE.
//  - In DONE: out_valid=1 with wreg_o=0.
//  Latency from the acceptance edge to the out_valid cycle:
//  - Non-memory op: 1 cycle.
//  - Load: N+2 cycles (LW: 6).
//  - Store: N+1 cycles (SW: 5).
//  out_valid=1 only in DONE.
//  - wd_o/wreg_o/wdata_o are registered.
//  - They hold their value until the next DONE.
//  stall_req is high when either holds:
//  - state is LOAD or STORE;
//  - in_valid & in_ready & (is_load|is_store).
//  Back-to-back: an op accepted in DONE starts on the next edge with no IDLE bubble.
//  Address arithmetic: addr + cnt is modulo 2^ADDR_W.
//  - 0xFFFFFFFF+1 wraps to 0.
//  - Misalignment is not checked.
//  mem_wr is 0 in every state except STORE.
//  rst low mid-access: aborts the sequence and drops mem_wr the same instant. No partial result reaches write-back.
// TESTING
//  - Non-memory op: ADD result 0x1234, wd=5, wreg=1 -> next cycle out_valid=1, wdata_o=0x1234, wreg_o=1, stall_req never high.
//  - LB at 0x100 with RAM[0x100]=0x80 -> mem_a=0x100 one cycle; wdata_o=0xFFFFFF80 at latency 3. LBU, same setup -> 0x00000080.
//  - LW at 0x200, RAM = 0x78,0x56,0x34,0x12 -> mem_a 0x200..0x203 on consecutive cycles; wdata_o=0x12345678 at latency 6; stall_req high for 5 cycles.
//  - SH at 0x300, data 0xAABBCCDD -> two writes: (0x300,0xDD) then (0x301,0xCC); out_valid with wreg_o=0 at latency 3; RAM[0x302] untouched.
//  - LW accepted in DONE of a prior SW -> no IDLE cycle between them. SW at 0xFFFFFFFE -> writes go to 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
//  - rst low during the 2nd byte of an SW -> mem_wr=0 immediately, state=IDLE, no out_valid after reset is released.

Source files
------------

// File: rtl/mem_stage_if.sv
// ----------------------------------------------------------------------------
// mem_stage_if : EX-side op handshake, byte-wide RAM port and write-back triple
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mem_stage_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              is_load;
  logic              is_store;
  logic [2:0]        funct3;
  logic [4:0]        wd_i;
  logic              wreg_i;
  logic [XLEN-1:0]   wdata_i;
  logic [XLEN-1:0]   mem_w_data_i;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_dout;
  logic              mem_wr;
  logic [7:0]        mem_din;
  logic              stall_req;
  logic              out_valid;
  logic [4:0]        wd_o;
  logic              wreg_o;
  logic [XLEN-1:0]   wdata_o;

  // The memory stage itself
  modport slave (
    input  in_valid, is_load, is_store, funct3, wd_i, wreg_i, wdata_i,
           mem_w_data_i, mem_din,
    output in_ready, mem_a, mem_dout, mem_wr, stall_req, out_valid,
           wd_o, wreg_o, wdata_o
  );

  // EX / RAM / write-back environment around the stage
  modport master (
    output in_valid, is_load, is_store, funct3, wd_i, wreg_i, wdata_i,
           mem_w_data_i, mem_din,
    input  in_ready, mem_a, mem_dout, mem_wr, stall_req, out_valid,
           wd_o, wreg_o, wdata_o
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage : RV32I memory stage, byte-serial little-endian loads/stores
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   sdata_q, sdata_d;
  logic [XLEN-1:0]   ldata_q, ldata_d;
  logic [4:0]        wd_q, wd_d;
  logic              wreg_q, wreg_d;
  logic [4:0]        wd_o_q, wd_o_d;
  logic              wreg_o_q, wreg_o_d;
  logic [XLEN-1:0]   wdata_o_q, wdata_o_d;

  logic              ready;
  logic              accept;
  logic [2:0]        n_bytes;
  logic [1:0]        bidx;
  logic [XLEN-1:0]   ld_full;
  logic [XLEN-1:0]   ld_ext;

  function automatic logic [2:0] byte_cnt(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   byte_cnt = 3'd1;
      2'b01:   byte_cnt = 3'd2;
      default: byte_cnt = 3'd4;
    endcase
  endfunction

  assign n_bytes = byte_cnt(f3_q);
  assign ready   = (state_q == IDLE) || (state_q == DONE);
  assign accept  = bus.in_valid && ready;
  // RAM data lags the address by one cycle, so cnt selects byte cnt-1
  assign bidx    = cnt_q[1:0] - 2'd1;

  always_comb begin
    ld_full = ldata_q;
    ld_full[{bidx, 3'b000} +: 8] = bus.mem_din;
    case (f3_q)
      3'b000:  ld_ext = {{(XLEN-8){ld_full[7]}},   ld_full[7:0]};
      3'b001:  ld_ext = {{(XLEN-16){ld_full[15]}}, ld_full[15:0]};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}},         ld_full[7:0]};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}},        ld_full[15:0]};
      default: ld_ext = ld_full;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    ldata_d   = ldata_q;
    wd_d      = wd_q;
    wreg_d    = wreg_q;
    wd_o_d    = wd_o_q;
    wreg_o_d  = wreg_o_q;
    wdata_o_d = wdata_o_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          cnt_d   = 3'd0;
          f3_d    = bus.funct3;
          addr_d  = bus.wdata_i[ADDR_W-1:0];
          sdata_d = bus.mem_w_data_i;
          wd_d    = bus.wd_i;
          wreg_d  = bus.wreg_i;
          if (bus.is_load) begin
            state_d = LOAD;
          end else if (bus.is_store) begin
            state_d = STORE;
          end else begin
            state_d   = DONE;
            wd_o_d    = bus.wd_i;
            wreg_o_d  = bus.wreg_i && (bus.wd_i != 5'd0);
            wdata_o_d = bus.wdata_i;
          end
        end
      end
      LOAD: begin
        if (cnt_q != 3'd0) begin
          ldata_d = ld_full;
        end
        if (cnt_q == n_bytes) begin
          state_d   = DONE;
          cnt_d     = 3'd0;
          wd_o_d    = wd_q;
          wreg_o_d  = wreg_q && (wd_q != 5'd0);
          wdata_o_d = ld_ext;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      STORE: begin
        if (cnt_q == n_bytes - 3'd1) begin
          state_d  = DONE;
          cnt_d    = 3'd0;
          wd_o_d   = wd_q;
          wreg_o_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      f3_q      <= 3'd0;
      addr_q    <= '0;
      sdata_q   <= '0;
      ldata_q   <= '0;
      wd_q      <= 5'd0;
      wreg_q    <= 1'b0;
      wd_o_q    <= 5'd0;
      wreg_o_q  <= 1'b0;
      wdata_o_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      ldata_q   <= ldata_d;
      wd_q      <= wd_d;
      wreg_q    <= wreg_d;
      wd_o_q    <= wd_o_d;
      wreg_o_q  <= wreg_o_d;
      wdata_o_q <= wdata_o_d;
    end
  end

  // RAM port is decoded from state so reset silences it without waiting for a clock
  assign bus.in_ready  = ready;
  assign bus.stall_req = (state_q == LOAD) || (state_q == STORE) ||
                         (accept && (bus.is_load || bus.is_store));
  assign bus.mem_wr    = (state_q == STORE);
  assign bus.mem_a     = ((state_q == STORE) || ((state_q == LOAD) && (cnt_q < n_bytes)))
                         ? addr_q + ADDR_W'(cnt_q) : '0;
  assign bus.mem_dout  = (state_q == STORE) ? sdata_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
  assign bus.out_valid = (state_q == DONE);
  assign bus.wd_o      = wd_o_q;
  assign bus.wreg_o    = wreg_o_q;
  assign bus.wdata_o   = wdata_o_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage : vector table, corner sequences and random ops vs. a byte-map model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if #(.ADDR_W(32), .XLEN(32)) bus ();
  mem_stage #(.ADDR_W(32), .XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] a;
    logic [31:0] sd;
  } op_t;

  typedef struct {
    op_t         op;
    logic [31:0] exp_data;
    bit          chk_data;
    logic        exp_wreg;
    int          exp_lat;
    int          exp_stall;
  } vec_t;

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  vec_t       tbl [16];
  logic [2:0] f3s [8];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cur_op = 0;
  int         k2;
  bit         seen2;

  // Byte-wide RAM: read data appears the cycle after the address
  always @(posedge clk) begin
    if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
    bus.mem_din <= ram.exists(bus.mem_a) ? ram[bus.mem_a] : 8'h00;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (op %0d): got 0x%08h, want 0x%08h", name, cur_op, act, exp);
    end
  endfunction

  function automatic int nbytes(logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [7:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a);
    longint v = 0;
    for (int i = 0; i < nbytes(f3); i++) v += longint'(ref_rd(a + 32'(i))) << (8 * i);
    if (f3 == 3'd0) v = (v ^ 64'h80) - 64'h80;
    if (f3 == 3'd1) v = (v ^ 64'h8000) - 64'h8000;
    return v[31:0];
  endfunction

  function automatic vec_t mk(logic ld, logic st, logic [2:0] f3, logic [4:0] rd, logic we,
                              logic [31:0] a, logic [31:0] sd, logic [31:0] ed, bit cd,
                              logic ew, int lat, int stl);
    vec_t v;
    v.op.ld = ld; v.op.st = st; v.op.f3 = f3; v.op.rd = rd; v.op.we = we;
    v.op.a = a; v.op.sd = sd;
    v.exp_data = ed; v.chk_data = cd; v.exp_wreg = ew; v.exp_lat = lat; v.exp_stall = stl;
    return v;
  endfunction

  task automatic drive_op(input op_t op);
    bus.in_valid     = 1'b1;
    bus.is_load      = op.ld;
    bus.is_store     = op.st;
    bus.funct3       = op.f3;
    bus.wd_i         = op.rd;
    bus.wreg_i       = op.we;
    bus.wdata_i      = op.a;
    bus.mem_w_data_i = op.sd;
  endtask

  task automatic scramble();
    bus.in_valid     = 1'b0;
    bus.is_load      = 1'($urandom);
    bus.is_store     = 1'($urandom);
    bus.funct3       = 3'($urandom);
    bus.wd_i         = 5'($urandom);
    bus.wreg_i       = 1'($urandom);
    bus.wdata_i      = $urandom;
    bus.mem_w_data_i = $urandom;
  endtask

  task automatic exec(input op_t op, input logic [31:0] exp_data, input bit chk_data,
                      input logic exp_wreg, input int exp_lat, input int exp_stall);
    int  n, lat, stalls, widx;
    bit  seen;
    n = nbytes(op.f3);
    @(negedge clk);
    drive_op(op);
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'd1);
    chk("stall_at_accept", 32'(bus.stall_req), 32'(op.ld | op.st));
    @(posedge clk);
    #1 scramble();
    lat = -1; stalls = 0; widx = 0; seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.stall_req) stalls++;
      if (op.ld && k <= n) chk("rd_addr", bus.mem_a, op.a + 32'(k - 1));
      if (bus.mem_wr) begin
        chk("wr_addr", bus.mem_a, op.a + 32'(widx));
        chk("wr_byte", 32'(bus.mem_dout), (op.sd >> (8 * widx)) & 32'hFF);
        widx++;
      end
      if (bus.out_valid) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    chk("write_count", 32'(widx), op.st ? 32'(n) : 32'd0);
    chk("wreg_o", 32'(bus.wreg_o), 32'(exp_wreg));
    if (!op.st) chk("wd_o", 32'(bus.wd_o), 32'(op.rd));
    if (chk_data) chk("wdata_o", bus.wdata_o, exp_data);
    if (op.st) for (int i = 0; i < n; i++) ref_mem[op.a + 32'(i)] = 8'(op.sd >> (8 * i));
    @(negedge clk);
    chk("pulse_end", 32'(bus.out_valid), 32'd0);
    if (chk_data) chk("hold_wdata", bus.wdata_o, exp_data);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   cnt;
    op_t  op;
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    tbl[0]  = mk(0, 0, 3'd0, 5'd5,  1, 32'h1234,     0,            32'h1234,     1, 1, 1, 0);
    tbl[1]  = mk(1, 0, 3'd0, 5'd6,  1, 32'h100,      0,            32'hFFFFFF80, 1, 1, 3, 2);
    tbl[2]  = mk(1, 0, 3'd4, 5'd6,  1, 32'h100,      0,            32'h00000080, 1, 1, 3, 2);
    tbl[3]  = mk(1, 0, 3'd2, 5'd7,  1, 32'h200,      0,            32'h12345678, 1, 1, 6, 5);
    tbl[4]  = mk(0, 1, 3'd1, 5'd7,  1, 32'h300,      32'hAABBCCDD, 0,            0, 0, 3, 2);
    tbl[5]  = mk(1, 0, 3'd1, 5'd8,  1, 32'h204,      0,            32'hFFFF8000, 1, 1, 4, 3);
    tbl[6]  = mk(1, 0, 3'd5, 5'd8,  1, 32'h204,      0,            32'h00008000, 1, 1, 4, 3);
    tbl[7]  = mk(1, 0, 3'd0, 5'd10, 1, 32'h201,      0,            32'h00000056, 1, 1, 3, 2);
    tbl[8]  = mk(0, 0, 3'd0, 5'd0,  1, 32'hDEADBEEF, 0,            32'hDEADBEEF, 1, 0, 1, 0);
    tbl[9]  = mk(0, 1, 3'd0, 5'd11, 1, 32'h310,      32'h000000A5, 0,            0, 0, 2, 1);
    tbl[10] = mk(0, 1, 3'd2, 5'd12, 0, 32'hFFFFFFFE, 32'h44332211, 0,            0, 0, 5, 4);
    tbl[11] = mk(1, 0, 3'd2, 5'd13, 1, 32'hFFFFFFFE, 0,            32'h44332211, 1, 1, 6, 5);
    tbl[12] = mk(1, 0, 3'd6, 5'd14, 1, 32'h200,      0,            32'h12345678, 1, 1, 6, 5);
    tbl[13] = mk(0, 0, 3'd3, 5'd3,  0, 32'h55AA,     0,            32'h000055AA, 1, 0, 1, 0);
    tbl[14] = mk(1, 0, 3'd5, 5'd15, 1, 32'h300,      0,            32'h0000CCDD, 1, 1, 4, 3);
    tbl[15] = mk(1, 0, 3'd0, 5'd16, 1, 32'h310,      0,            32'hFFFFFFA5, 1, 1, 3, 2);

    ram[32'h100] = 8'h80; ref_mem[32'h100] = 8'h80;
    ram[32'h200] = 8'h78; ref_mem[32'h200] = 8'h78;
    ram[32'h201] = 8'h56; ref_mem[32'h201] = 8'h56;
    ram[32'h202] = 8'h34; ref_mem[32'h202] = 8'h34;
    ram[32'h203] = 8'h12; ref_mem[32'h203] = 8'h12;
    ram[32'h204] = 8'h00; ref_mem[32'h204] = 8'h00;
    ram[32'h205] = 8'h80; ref_mem[32'h205] = 8'h80;

    rst = 1'b0;
    scramble();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_wreg_o", 32'(bus.wreg_o), 32'd0);
    chk("rst_wd_o", 32'(bus.wd_o), 32'd0);
    chk("rst_wdata_o", bus.wdata_o, 32'd0);
    chk("rst_mem_a", bus.mem_a, 32'd0);
    chk("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
    chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      cur_op = i;
      exec(tbl[i].op, tbl[i].exp_data, tbl[i].chk_data, tbl[i].exp_wreg,
           tbl[i].exp_lat, tbl[i].exp_stall);
    end
    cur_op = 90;
    chk("sh_byte2_untouched", 32'(ram.exists(32'h302)), 32'd0);

    // SW then LW held on in_valid: LW must be taken in the SW's DONE cycle
    cur_op = 100;
    @(negedge clk);
    op.ld = 0; op.st = 1; op.f3 = 3'd2; op.rd = 5'd0; op.we = 0; op.a = 32'h600; op.sd = 32'hCAFEF00D;
    drive_op(op);
    @(posedge clk);
    #1;
    op.ld = 1; op.st = 0; op.rd = 5'd9; op.we = 1; op.sd = $urandom;
    drive_op(op);
    k2 = -1; seen2 = 1'b0;
    for (int c = 1; c <= 20 && !seen2; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin seen2 = 1'b1; k2 = c; end
    end
    chk("b2b_sw_latency", 32'(k2), 32'd5);
    chk("b2b_sw_wreg_o", 32'(bus.wreg_o), 32'd0);
    @(posedge clk);
    #1 scramble();
    @(negedge clk);
    chk("b2b_no_bubble_ready", 32'(bus.in_ready), 32'd0);
    chk("b2b_no_bubble_stall", 32'(bus.stall_req), 32'd1);
    k2 = -1; seen2 = 1'b0;
    for (int c = 1; c <= 20 && !seen2; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.out_valid) begin seen2 = 1'b1; k2 = c; end
    end
    chk("b2b_lw_latency", 32'(k2), 32'd6);
    chk("b2b_lw_wdata", bus.wdata_o, 32'hCAFEF00D);
    chk("b2b_lw_wreg_o", 32'(bus.wreg_o), 32'd1);
    chk("b2b_lw_wd_o", 32'(bus.wd_o), 32'd9);
    for (int i = 0; i < 4; i++) ref_mem[32'h600 + 32'(i)] = 8'(32'hCAFEF00D >> (8 * i));

    for (int i = 0; i < 60; i++) begin
      int          kind;
      int          n;
      logic [31:0] ed;
      cur_op = 1000 + i;
      kind   = $urandom_range(0, 2);
      op.ld  = (kind == 1);
      op.st  = (kind == 2);
      op.f3  = f3s[$urandom_range(0, 7)];
      op.rd  = 5'($urandom);
      op.we  = 1'($urandom);
      op.sd  = $urandom;
      op.a   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                           : 32'h1000 + 32'($urandom_range(0, 31));
      n = nbytes(op.f3);
      if (kind == 0) begin
        op.a = $urandom;
        exec(op, op.a, 1, op.we && (op.rd != 0), 1, 0);
      end else if (kind == 1) begin
        ed = ref_load(op.f3, op.a);
        exec(op, ed, 1, op.we && (op.rd != 0), n + 2, n + 1);
      end else begin
        exec(op, 32'd0, 0, 1'b0, n + 1, n);
      end
    end

    cur_op = 2000;
    foreach (ref_mem[key])
      chk("ram_contents", ram.exists(key) ? 32'(ram[key]) : 32'h100, 32'(ref_mem[key]));

    // Reset asserted while the second byte of a word store is on the bus
    cur_op = 3000;
    @(negedge clk);
    op.ld = 0; op.st = 1; op.f3 = 3'd2; op.rd = 5'd4; op.we = 1; op.a = 32'h500; op.sd = 32'h11223344;
    drive_op(op);
    @(posedge clk);
    #1 scramble();
    @(negedge clk);
    chk("abort_b0_wr", 32'(bus.mem_wr), 32'd1);
    @(negedge clk);
    chk("abort_b1_addr", bus.mem_a, 32'h501);
    #2 rst = 1'b0;
    #1;
    chk("abort_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("abort_mem_a", bus.mem_a, 32'd0);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_idle_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_stall", 32'(bus.stall_req), 32'd0);
    chk("abort_wdata_o", bus.wdata_o, 32'd0);
    chk("abort_wreg_o", 32'(bus.wreg_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    chk("abort_no_out_valid", 32'(cnt), 32'd0);
    chk("abort_b1_unwritten", 32'(ram.exists(32'h501)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
